// File: rtl/addr_map_rule_pkg.sv
// Address-map rule type shared by bus decoders: [start_addr, end_addr) tagged with its index.
package addr_map_rule_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

endpackage

// File: rtl/ext_xbar_pkg.sv
// External accelerator address map, decode-error data and select encoding for ext_obi_addr_demux.
package ext_xbar_pkg;

    import addr_map_rule_pkg::*;

    localparam int unsigned EXT_XBAR_NSLAVE = 2;

    localparam logic [31:0] ACC0_START_ADDRESS = 32'h2000_0000;
    localparam logic [31:0] ACC0_SIZE          = 32'h0020_0000;
    localparam logic [31:0] ACC0_END_ADDRESS   = ACC0_START_ADDRESS + ACC0_SIZE;
    localparam logic [31:0] ACC0_IDX           = 32'd0;

    localparam logic [31:0] ACC1_START_ADDRESS = 32'h2020_0000;
    localparam logic [31:0] ACC1_SIZE          = 32'h0001_0000;
    localparam logic [31:0] ACC1_END_ADDRESS   = ACC1_START_ADDRESS + ACC1_SIZE;
    localparam logic [31:0] ACC1_IDX           = 32'd1;

    localparam addr_map_rule_t [EXT_XBAR_NSLAVE-1:0] EXT_XBAR_ADDR_RULES = {
        addr_map_rule_t'{idx: ACC1_IDX, start_addr: ACC1_START_ADDRESS, end_addr: ACC1_END_ADDRESS},
        addr_map_rule_t'{idx: ACC0_IDX, start_addr: ACC0_START_ADDRESS, end_addr: ACC0_END_ADDRESS}
    };

    localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;

    // Slave indices 0..NSLAVE-1, value NSLAVE marks a decode error.
    localparam int unsigned EXT_SEL_W = $clog2(EXT_XBAR_NSLAVE + 1);
    typedef logic [EXT_SEL_W-1:0] ext_sel_t;

endpackage

// File: rtl/ext_obi_sel_fifo.sv
// In-flight select FIFO: records the target of each accepted request so responses return in order.
module ext_obi_sel_fifo
    import ext_xbar_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(ext_sel_t)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head is only visible once the entry is registered (no fall-through).
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ext_obi_addr_demux.sv
// OBI 1-to-NSLAVE address demultiplexer with in-order responses and an internal decode-error responder.
module ext_obi_addr_demux
    import addr_map_rule_pkg::*;
#(
    parameter int unsigned                 NSLAVE          = 2,
    parameter int unsigned                 MAX_OUTSTANDING = 2,
    parameter addr_map_rule_t [NSLAVE-1:0] RULES           = ext_xbar_pkg::EXT_XBAR_ADDR_RULES,
    parameter logic [31:0]                 ERR_RDATA       = ext_xbar_pkg::ERR_RDATA
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     m_req_i,
    input  logic [31:0]              m_addr_i,
    input  logic                     m_we_i,
    input  logic [3:0]               m_be_i,
    input  logic [31:0]              m_wdata_i,
    output logic                     m_gnt_o,
    output logic                     m_rvalid_o,
    output logic [31:0]              m_rdata_o,
    output logic [NSLAVE-1:0]        s_req_o,
    output logic [31:0]              s_addr_o,
    output logic                     s_we_o,
    output logic [3:0]               s_be_o,
    output logic [31:0]              s_wdata_o,
    input  logic [NSLAVE-1:0]        s_gnt_i,
    input  logic [NSLAVE-1:0]        s_rvalid_i,
    input  logic [NSLAVE-1:0][31:0]  s_rdata_i,
    output logic [15:0]              dec_err_cnt_o,
    output logic                     proto_err_o
);

    localparam int unsigned      SEL_W   = $clog2(NSLAVE + 1);
    localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(NSLAVE);

    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  head;
    logic [NSLAVE-1:0] sel_oh;
    logic [NSLAVE-1:0] head_oh;
    logic              sel_err;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [15:0]       dec_err_cnt_q, dec_err_cnt_d;
    logic              proto_err_q, proto_err_d;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    // Scan downwards so the lowest matching rule index wins on overlap.
    always_comb begin
        sel = SEL_ERR;
        for (int k = int'(NSLAVE) - 1; k >= 0; k--) begin
            if (m_addr_i >= RULES[k].start_addr && m_addr_i < RULES[k].end_addr) begin
                sel = SEL_W'(k);
            end
        end
    end

    assign sel_err = (sel == SEL_ERR);

    always_comb begin
        sel_oh  = '0;
        head_oh = '0;
        for (int k = 0; k < int'(NSLAVE); k++) begin
            sel_oh[k]  = (sel == SEL_W'(k));
            head_oh[k] = !empty && (head == SEL_W'(k));
        end
    end

    always_comb begin
        s_req_o = '0;
        m_gnt_o = 1'b0;
        if (!rst_i && !full) begin
            if (sel_err) begin
                m_gnt_o = m_req_i;
            end else begin
                s_req_o = sel_oh & {NSLAVE{m_req_i}};
                m_gnt_o = |(s_gnt_i & sel_oh);
            end
        end
    end

    assign push = m_req_i && m_gnt_o;

    // Response mux follows the FIFO head; an ERR head answers immediately.
    always_comb begin
        m_rvalid_o = 1'b0;
        m_rdata_o  = '0;
        pop        = 1'b0;
        if (!rst_i && !empty) begin
            if (head == SEL_ERR) begin
                m_rvalid_o = 1'b1;
                m_rdata_o  = ERR_RDATA;
                pop        = 1'b1;
            end else begin
                for (int k = 0; k < int'(NSLAVE); k++) begin
                    if (head_oh[k]) begin
                        m_rvalid_o = s_rvalid_i[k];
                        m_rdata_o  = s_rdata_i[k];
                        pop        = s_rvalid_i[k];
                    end
                end
            end
        end
    end

    always_comb begin
        dec_err_cnt_d = dec_err_cnt_q;
        proto_err_d   = proto_err_q | (|(s_rvalid_i & ~head_oh));
        if (push && sel_err && dec_err_cnt_q != 16'hFFFF) begin
            dec_err_cnt_d = dec_err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_err_cnt_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            dec_err_cnt_q <= dec_err_cnt_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign dec_err_cnt_o = dec_err_cnt_q;
    assign proto_err_o   = proto_err_q;

    ext_obi_sel_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (SEL_W)
    ) u_sel_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
